// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI types and helpers for the write-response tracker
// Purpose: AXI response codes, ID/response widths, holding-register state
//          encoding and the error-response classifier.
// Ports:   none (package)
package axi_pkg;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_RESP_W = 2;

    typedef enum logic [AXI_RESP_W-1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_e;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_st_e;

    function automatic logic is_err_resp(input logic [AXI_RESP_W-1:0] resp);
        return (resp_e'(resp) == SLVERR) || (resp_e'(resp) == DECERR);
    endfunction

endpackage

// File: rtl/wr_rsp_out_cnt.sv
// rtl/wr_rsp_out_cnt.sv - per-ID outstanding write counter
// Purpose: up/down counter of writes issued but not yet answered for one ID.
// Ports:   clk, rst (sync active-high); inc/dec pulses; cnt value;
//          full (cnt == MAX_OUT) and empty (cnt == 0) flags.
module wr_rsp_out_cnt #(
    parameter int MAX_OUT = 8,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             empty
);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Simultaneous inc and dec cancel; the limits are guarded here as well so
    // the counter can never wrap even if a caller misbehaves.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec && (cnt_q != CNT_W'(MAX_OUT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt   = cnt_q;
    assign full  = (cnt_q == CNT_W'(MAX_OUT));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/axi_wr_rsp_tracker.sv
// rtl/axi_wr_rsp_tracker.sv - AXI B-channel sharing and outstanding-write tracker
// Purpose: counts outstanding writes per AWID, accepts B beats, routes each
//          expected beat to its requester through a 1-entry holding register,
//          flags unexpected B / AW overflow and counts error responses.
// Ports:   clk, rst (sync active-high); aw_fire/aw_id/aw_stall (AW side);
//          bvalid/bready/bid/bresp/buser (B channel);
//          done_valid/done_ready/done_resp (per-requester completion);
//          busy, err_cnt, err_unexp, err_clr (status);
//          timeout (only when WR_RSP_TIMEOUT_EN is defined).
// Option:  WR_RSP_TIMEOUT_EN adds the watchdog and buser checking.
module axi_wr_rsp_tracker
    import axi_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MAX_OUT     = 8,
    parameter int CNT_W       = 4,
    parameter int ERR_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  aw_fire,
    input  logic [AXI_ID_W-1:0]   aw_id,
    output logic [NUM_REQ-1:0]    aw_stall,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [AXI_ID_W-1:0]   bid,
    input  logic [AXI_RESP_W-1:0] bresp,
    input  logic                  buser,
    output logic [NUM_REQ-1:0]    done_valid,
    input  logic [NUM_REQ-1:0]    done_ready,
    output logic [AXI_RESP_W-1:0] done_resp,
    output logic                  busy,
    output logic [ERR_W-1:0]      err_cnt,
    output logic                  err_unexp,
    input  logic                  err_clr
`ifdef WR_RSP_TIMEOUT_EN
    ,
    output logic                  timeout
`endif
);

    logic [NUM_REQ-1:0][CNT_W-1:0] cnt;
    logic [NUM_REQ-1:0] cnt_full, cnt_empty, cnt_inc, cnt_dec;
    logic [NUM_REQ-1:0] aw_sel, bid_sel, hold_sel;
    logic b_acc, b_exp, b_unexp, aw_bad, done_hs, any_out, buser_err;

    hold_st_e              hold_st_d, hold_st_q;
    logic [AXI_ID_W-1:0]   hold_id_d, hold_id_q;
    logic [AXI_RESP_W-1:0] hold_resp_d, hold_resp_q;
    logic [ERR_W-1:0]      err_cnt_d, err_cnt_q;
    logic                  err_unexp_d, err_unexp_q;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        wr_rsp_out_cnt #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (cnt_inc[g]),
            .dec   (cnt_dec[g]),
            .cnt   (cnt[g]),
            .full  (cnt_full[g]),
            .empty (cnt_empty[g])
        );
    end

    // One-hot decodes; an out-of-range ID simply decodes to all zeros.
    always_comb begin
        aw_sel   = '0;
        bid_sel  = '0;
        hold_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            aw_sel[i]   = aw_fire && (aw_id == AXI_ID_W'(i));
            bid_sel[i]  = (bid == AXI_ID_W'(i));
            hold_sel[i] = (hold_st_q == HOLD_FULL) && (hold_id_q == AXI_ID_W'(i));
        end
    end

    assign done_hs = |(hold_sel & done_ready);
    // Ready looks straight through to the holder's done_ready so a draining
    // register can take the next beat in the same cycle.
    assign bready  = !rst && ((hold_st_q == HOLD_EMPTY) || done_hs);
    assign b_acc   = bvalid && bready;
    // A same-cycle AW on the same ID makes a zero count acceptable.
    assign b_exp   = b_acc && |(bid_sel & (~cnt_empty | aw_sel));
    assign b_unexp = b_acc && !b_exp;
    assign aw_bad  = aw_fire && (!(|aw_sel) || |(aw_sel & cnt_full));
    assign cnt_inc = aw_sel & ~cnt_full;
    assign cnt_dec = b_exp ? bid_sel : '0;
    assign any_out = |(~cnt_empty);

`ifdef WR_RSP_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_d, wd_q;
    logic            timeout_d, timeout_q;

    assign buser_err = b_exp && buser;

    always_comb begin
        wd_d      = wd_q;
        timeout_d = timeout_q | (wd_q == WD_W'(TIMEOUT_CYC));
        if (err_clr || b_acc || !any_out) begin
            wd_d = '0;
        end else if (wd_q != WD_W'(TIMEOUT_CYC)) begin
            wd_d = wd_q + WD_W'(1);
        end
        if (err_clr) begin
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic [1:0] unused_cfg;
    assign unused_cfg = {buser, (TIMEOUT_CYC == 0)};
    assign buser_err  = 1'b0;
`endif

    always_comb begin
        hold_st_d   = hold_st_q;
        hold_id_d   = hold_id_q;
        hold_resp_d = hold_resp_q;
        if (b_exp) begin
            hold_st_d   = HOLD_FULL;
            hold_id_d   = bid;
            hold_resp_d = bresp;
        end else if (done_hs) begin
            hold_st_d   = HOLD_EMPTY;
        end

        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (b_exp && is_err_resp(bresp) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end

        err_unexp_d = err_clr ? 1'b0 : (err_unexp_q | aw_bad | b_unexp | buser_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_st_q   <= HOLD_EMPTY;
            hold_id_q   <= '0;
            hold_resp_q <= '0;
            err_cnt_q   <= '0;
            err_unexp_q <= 1'b0;
        end else begin
            hold_st_q   <= hold_st_d;
            hold_id_q   <= hold_id_d;
            hold_resp_q <= hold_resp_d;
            err_cnt_q   <= err_cnt_d;
            err_unexp_q <= err_unexp_d;
        end
    end

    assign aw_stall   = cnt_full;
    assign done_valid = hold_sel;
    assign done_resp  = hold_resp_q;
    assign busy       = any_out || (hold_st_q == HOLD_FULL);
    assign err_cnt    = err_cnt_q;
    assign err_unexp  = err_unexp_q;

endmodule

// File: tb/tb_axi_wr_rsp_tracker.sv
// tb/tb_axi_wr_rsp_tracker.sv - directed self-checking bench for axi_wr_rsp_tracker
module tb_axi_wr_rsp_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic        aw_fire;
    logic [3:0]  aw_id;
    logic [3:0]  aw_stall;
    logic        bvalid;
    logic        bready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        buser;
    logic [3:0]  done_valid;
    logic [3:0]  done_ready;
    logic [1:0]  done_resp;
    logic        busy;
    logic [15:0] err_cnt;
    logic        err_unexp;
    logic        err_clr;
`ifdef WR_RSP_TIMEOUT_EN
    logic        timeout;
`endif

    int n_checks = 0;
    int n_errors = 0;

    axi_wr_rsp_tracker #(
        .NUM_REQ(4), .MAX_OUT(8), .CNT_W(4), .ERR_W(16), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst),
        .aw_fire(aw_fire), .aw_id(aw_id), .aw_stall(aw_stall),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp), .buser(buser),
        .done_valid(done_valid), .done_ready(done_ready), .done_resp(done_resp),
        .busy(busy), .err_cnt(err_cnt), .err_unexp(err_unexp), .err_clr(err_clr)
`ifdef WR_RSP_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_pulse();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; aw_fire = 0; aw_id = 0; bvalid = 0; bid = 0; bresp = 0;
        buser = 0; done_ready = 4'h0; err_clr = 0;
        tick();
        tick();
        chk("rst_bready", 32'(bready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_bready", 32'(bready), 32'd1);
        chk("rst_done_valid", 32'(done_valid), 32'd0);
        chk("rst_done_resp", 32'(done_resp), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_err_unexp", 32'(err_unexp), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_aw_stall", 32'(aw_stall), 32'd0);
        tick();

        // AW ids 0,1,1 then B bid=1 OKAY
        aw_fire = 1; aw_id = 0; tick();
        aw_id = 1; tick();
        aw_id = 1; tick();
        aw_fire = 0;
        chk("t1_cnt1_before", 32'(dut.cnt[1]), 32'd2);
        bvalid = 1; bid = 1; bresp = 2'd0; done_ready = 4'hf;
        #1;
        chk("t1_bready", 32'(bready), 32'd1);
        tick();
        bvalid = 0;
        chk("t1_done_valid", 32'(done_valid), 32'b0010);
        chk("t1_done_resp", 32'(done_resp), 32'd0);
        chk("t1_cnt1", 32'(dut.cnt[1]), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_done_drained", 32'(done_valid), 32'd0);

        // 8 AWs on id 2 then an overflowing 9th
        aw_fire = 1; aw_id = 2;
        for (int i = 0; i < 7; i++) tick();
        chk("t2_no_stall_at_7", 32'(aw_stall), 32'b0000);
        tick();
        aw_fire = 0;
        chk("t2_stall", 32'(aw_stall), 32'b0100);
        chk("t2_no_err_yet", 32'(err_unexp), 32'd0);
        aw_fire = 1; aw_id = 2; tick();
        aw_fire = 0;
        chk("t2_overflow_err", 32'(err_unexp), 32'd1);
        chk("t2_cnt2", 32'(dut.cnt[2]), 32'd8);
        clr_pulse();
        chk("t2_cleared", 32'(err_unexp), 32'd0);

        // AW with id out of range
        aw_fire = 1; aw_id = 4'd9; tick();
        aw_fire = 0;
        chk("t2b_bad_id_err", 32'(err_unexp), 32'd1);
        clr_pulse();

        // Unexpected B on id 3
        bvalid = 1; bid = 3; bresp = 0;
        #1;
        chk("t3_bready", 32'(bready), 32'd1);
        tick();
        bvalid = 0;
        chk("t3_no_done", 32'(done_valid), 32'd0);
        chk("t3_err_unexp", 32'(err_unexp), 32'd1);
        chk("t3_cnt3", 32'(dut.cnt[3]), 32'd0);
        clr_pulse();

        // Backpressure: cnt0=1, cnt1=1
        done_ready = 4'h0;
        bvalid = 1; bid = 0; bresp = 2'd0;
        tick();
        bid = 1; bresp = 2'd1;
        #1;
        chk("t4_bready_low0", 32'(bready), 32'd0);
        chk("t4_dv0", 32'(done_valid), 32'b0001);
        tick();
        chk("t4_bready_low1", 32'(bready), 32'd0);
        chk("t4_resp_stable", 32'(done_resp), 32'd0);
        chk("t4_cnt1_held", 32'(dut.cnt[1]), 32'd1);
        tick();
        chk("t4_bready_low2", 32'(bready), 32'd0);
        done_ready = 4'b0001;
        #1;
        chk("t4_bready_pass", 32'(bready), 32'd1);
        tick();
        done_ready = 4'h0; bvalid = 0;
        chk("t4_reload", 32'(done_valid), 32'b0010);
        chk("t4_reload_resp", 32'(done_resp), 32'd1);
        chk("t4_cnt1", 32'(dut.cnt[1]), 32'd0);
        chk("t4_cnt0", 32'(dut.cnt[0]), 32'd0);
        done_ready = 4'hf;
        tick();
        chk("t4_drained", 32'(done_valid), 32'd0);

        // Error responses on id 2 (cnt2 = 8)
        bvalid = 1; bid = 2; bresp = 2'd2; tick();
        bresp = 2'd2; tick();
        bresp = 2'd3; tick();
        bvalid = 0;
        tick();
        chk("t5_err_cnt", 32'(err_cnt), 32'd3);
        chk("t5_cnt2", 32'(dut.cnt[2]), 32'd5);
        chk("t5_no_unexp", 32'(err_unexp), 32'd0);
        clr_pulse();
        chk("t5_err_clr", 32'(err_cnt), 32'd0);
        bvalid = 1; bid = 2; bresp = 2'd2; err_clr = 1;
        tick();
        bvalid = 0; err_clr = 0;
        chk("t5_clr_priority", 32'(err_cnt), 32'd0);
        chk("t5_cnt2_dec", 32'(dut.cnt[2]), 32'd4);
        tick();

        // Same-cycle AW and B on id 3 with zero count
        aw_fire = 1; aw_id = 3; bvalid = 1; bid = 3; bresp = 0;
        tick();
        aw_fire = 0; bvalid = 0;
        chk("t6_cnt3", 32'(dut.cnt[3]), 32'd0);
        chk("t6_no_unexp", 32'(err_unexp), 32'd0);
        chk("t6_done", 32'(done_valid), 32'b1000);
        tick();

        // Reset mid-transaction
        aw_fire = 1; aw_id = 0; tick();
        aw_fire = 0; done_ready = 4'h0; bvalid = 1; bid = 2; bresp = 2'd3;
        tick();
        bvalid = 0;
        chk("t7_held", 32'(done_valid), 32'b0100);
        rst = 1;
        #1;
        chk("t7_bready_rst", 32'(bready), 32'd0);
        tick();
        chk("t7_dv", 32'(done_valid), 32'd0);
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_err_cnt", 32'(err_cnt), 32'd0);
        chk("t7_stall", 32'(aw_stall), 32'd0);
        chk("t7_resp", 32'(done_resp), 32'd0);
        rst = 0;
        #1;
        chk("t7_bready_after", 32'(bready), 32'd1);
        tick();

`ifdef WR_RSP_TIMEOUT_EN
        aw_fire = 1; aw_id = 0; tick();
        aw_fire = 0;
        chk("t8_no_timeout", 32'(timeout), 32'd0);
        for (int i = 0; i < 20; i++) tick();
        chk("t8_timeout", 32'(timeout), 32'd1);
        rst = 1; tick();
        rst = 0;
        chk("t8_timeout_rst", 32'(timeout), 32'd0);
        chk("t8_busy_rst", 32'(busy), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
